// File: rtl/tag_fifo.sv
// tag_fifo - free-tag allocator feeding ROB tags to dispatch.
//
// A circular FIFO of free ROB tags. It starts out holding every tag 0..DEPTH-1.
// Dispatch pops the head tag, a retiring instruction pushes its tag back, and
// a mispredict flush restores the full initial pool.
//
// Ports:
//   clock            single clock, rising-edge state updates
//   reset            synchronous active-low reset (priority over all inputs)
//   Dispatch_tag_req dispatch consumes Tag_out this cycle (pop)
//   Retire_valid     ROB retiring; Retire_rd_tag returns to the pool (push)
//   Retire_rd_tag    tag being freed
//   Flush            mispredict: every tag becomes free again
//   Tag_out          next free tag (first-word fall-through)
//   Tag_valid        Tag_out is valid
//   Tag_count        number of free tags, 0..DEPTH
//   Tag_full         Tag_count == DEPTH
//   Overflow_err     sticky: push attempted while full, cleared by reset only
//
// Optional build macro: TAG_FIFO_BYPASS_EN
//   When defined, a tag retiring into an empty pool is visible on Tag_out in
//   the same cycle. A same-cycle dispatch request consumes it directly.

module tag_fifo #(
  parameter int TAG_W = 5,
  parameter int DEPTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             Dispatch_tag_req,
  input  logic             Retire_valid,
  input  logic [TAG_W-1:0] Retire_rd_tag,
  input  logic             Flush,
  output logic [TAG_W-1:0] Tag_out,
  output logic             Tag_valid,
  output logic [TAG_W:0]   Tag_count,
  output logic             Tag_full,
  output logic             Overflow_err
);

  localparam logic [TAG_W:0] C_DEPTH = (TAG_W+1)'(DEPTH);

  logic [TAG_W-1:0] r_mem [DEPTH];
  logic [TAG_W-1:0] r_rd_ptr;
  logic [TAG_W-1:0] r_wr_ptr;
  logic [TAG_W:0]   r_count;
  logic             r_ovf;

  logic             w_empty;
  logic             w_full;
  logic             w_init;
  logic             w_pop;
  logic             w_push;
  logic [DEPTH-1:0] w_wr_sel;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == C_DEPTH);
  // Reset and flush both rebuild the pool. Only reset clears the sticky error.
  assign w_init  = !reset || Flush;

`ifdef TAG_FIFO_BYPASS_EN
  logic w_bypass;

  // The pool is empty and a tag is retiring, so hand that tag straight to
  // dispatch.
  assign w_bypass  = w_empty && Retire_valid && !Flush;
  assign w_pop     = Dispatch_tag_req && !w_empty;
  // A bypassed tag that dispatch consumes never touches the storage.
  assign w_push    = Retire_valid && !w_full && !(w_bypass && Dispatch_tag_req);
  assign Tag_out   = w_bypass ? Retire_rd_tag : r_mem[r_rd_ptr];
  assign Tag_valid = !w_empty || w_bypass;
`else
  assign w_pop     = Dispatch_tag_req && !w_empty;
  assign w_push    = Retire_valid && !w_full;
  assign Tag_out   = r_mem[r_rd_ptr];
  assign Tag_valid = !w_empty;
`endif

  // One-hot write select per storage entry.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
      assign w_wr_sel[gi] = w_push && (r_wr_ptr == TAG_W'(gi));
    end
  endgenerate

  // Storage is reset to the identity map. Because of that reset it is built
  // from registers rather than block RAM.
  always_ff @(posedge clock) begin
    if (w_init) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= TAG_W'(i);
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_wr_sel[i]) begin
          r_mem[i] <= Retire_rd_tag;
        end
      end
    end
  end

  // Pointers are exactly TAG_W bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= C_DEPTH;
      r_ovf    <= 1'b0;
    end else if (Flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= C_DEPTH;
    end else begin
      if (Retire_valid && w_full) begin
        r_ovf <= 1'b1;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + TAG_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + TAG_W'(1);
      end
      r_count <= r_count + (TAG_W+1)'(w_push) - (TAG_W+1)'(w_pop);
    end
  end

  assign Tag_count    = r_count;
  assign Tag_full     = w_full;
  assign Overflow_err = r_ovf;

endmodule
